// File: rtl/e203_exu_fpu_fmis_sgnj_req_if.sv
// Handshake bundle between the EXU-side environment and the FPU sign-injection
// request block.
//   master : environment side (dispatch, sign-injection responder, writeback arbiter)
//   slave  : e203_exu_fpu_fmis_sgnj_req itself
// Signal groups:
//   req_*  / flush : dispatch request channel
//   sgnj_i_* / sgnj_rs1/rs2/flag : operands toward the responder
//   sgnj_o_* / sgnj_wdat         : result from the responder
//   wbck_*         : FIFO head toward the writeback arbiter
//   tmo_err        : sticky hung-responder flag
interface e203_exu_fpu_fmis_sgnj_req_if #(
  parameter int ITAG_W = 2
);
  logic              req_valid;
  logic              req_ready;
  logic [31:0]       req_rs1;
  logic [31:0]       req_rs2;
  logic [1:0]        req_flag;
  logic [ITAG_W-1:0] req_itag;
  logic              flush;

  logic              sgnj_i_valid;
  logic              sgnj_i_ready;
  logic [31:0]       sgnj_rs1;
  logic [31:0]       sgnj_rs2;
  logic [1:0]        sgnj_flag;

  logic              sgnj_o_valid;
  logic              sgnj_o_ready;
  logic [31:0]       sgnj_wdat;

  logic              wbck_valid;
  logic              wbck_ready;
  logic [31:0]       wbck_wdat;
  logic [ITAG_W-1:0] wbck_itag;
  logic              wbck_ill;

  logic              tmo_err;

  modport master (
    output req_valid, req_rs1, req_rs2, req_flag, req_itag, flush,
    output sgnj_i_ready, sgnj_o_valid, sgnj_wdat, wbck_ready,
    input  req_ready, sgnj_i_valid, sgnj_rs1, sgnj_rs2, sgnj_flag, sgnj_o_ready,
    input  wbck_valid, wbck_wdat, wbck_itag, wbck_ill, tmo_err
  );

  modport slave (
    input  req_valid, req_rs1, req_rs2, req_flag, req_itag, flush,
    input  sgnj_i_ready, sgnj_o_valid, sgnj_wdat, wbck_ready,
    output req_ready, sgnj_i_valid, sgnj_rs1, sgnj_rs2, sgnj_flag, sgnj_o_ready,
    output wbck_valid, wbck_wdat, wbck_itag, wbck_ill, tmo_err
  );
endinterface

// File: rtl/e203_exu_fpu_fmis_sgnj_req.sv
// Initiator side of the FPU misc sign-injection handshake.
// Accepts FSGNJ/FSGNJN/FSGNJX requests from dispatch, registers the operands
// toward the responder, collects the result and queues it in a 2-entry FIFO
// for the writeback arbiter. Illegal flags (3) bypass the responder and queue
// a zero result marked ill. Flush kills a request the responder has not yet
// taken. A hung responder raises the sticky tmo_err after TMO_CYC ISSUE cycles.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave modport of e203_exu_fpu_fmis_sgnj_req_if
//
// state  | meaning
// IDLE   | no request held, may accept from dispatch
// LOAD   | operands latched, responder handshake starts next cycle
// ISSUE  | offering operands / waiting for result until both handshakes done
module e203_exu_fpu_fmis_sgnj_req #(
  parameter int ITAG_W  = 2,
  parameter int TMO_CYC = 64
) (
  input  logic clk,
  input  logic rst,
  e203_exu_fpu_fmis_sgnj_req_if.slave bus
);

  localparam int CNT_W = $clog2(TMO_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       rs1_q, rs2_q;
  logic [1:0]        flag_q;
  logic [ITAG_W-1:0] itag_q;
  logic              i_done_q, o_done_q;
  logic [CNT_W-1:0]  tmo_cnt_q;
  logic              tmo_err_q;

  logic [31:0]       f_wdat [2];
  logic [ITAG_W-1:0] f_itag [2];
  logic              f_ill  [2];
  logic              wr_ptr, rd_ptr;
  logic [1:0]        f_cnt;

  logic              fifo_full, req_rdy, accept, acc_ill, acc_op;
  logic              i_vld, o_rdy, i_hs, o_hs, i_done_nx, o_done_nx, kill;
  logic              push, pop;
  logic [31:0]       push_wdat;
  logic [ITAG_W-1:0] push_itag;
  logic              push_ill;

  assign fifo_full = (f_cnt == 2'd2);
  // rst gating keeps req_ready low while the rest of the block is held in reset
  assign req_rdy   = !rst && (state_q == S_IDLE) && !fifo_full && !bus.flush;
  assign accept    = bus.req_valid && req_rdy;
  assign acc_ill   = accept && (bus.req_flag == 2'd3);
  assign acc_op    = accept && (bus.req_flag != 2'd3);

  assign i_vld     = (state_q == S_ISSUE) && !i_done_q;
  // result is only taken when there is room, so a capture is never lost
  assign o_rdy     = (state_q == S_ISSUE) && !o_done_q && !fifo_full;
  assign i_hs      = i_vld && bus.sgnj_i_ready;
  assign o_hs      = o_rdy && bus.sgnj_o_valid;
  assign i_done_nx = i_done_q || i_hs;
  assign o_done_nx = o_done_q || o_hs;
  // once the responder has taken the operands (even this cycle) flush is moot
  assign kill      = bus.flush && (state_q != S_IDLE) && !i_done_q && !i_hs;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (acc_op) state_d = S_LOAD;
      S_LOAD:  state_d = kill ? S_IDLE : S_ISSUE;
      S_ISSUE: begin
        if (kill)                        state_d = S_IDLE;
        else if (i_done_nx && o_done_nx) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // an illegal accept only happens in IDLE, a result capture only in ISSUE,
  // so at most one push source is active per cycle
  assign push      = acc_ill || o_hs;
  assign push_wdat = acc_ill ? 32'd0 : bus.sgnj_wdat;
  assign push_itag = acc_ill ? bus.req_itag : itag_q;
  assign push_ill  = acc_ill;
  assign pop       = (f_cnt != 2'd0) && bus.wbck_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rs1_q     <= '0;
      rs2_q     <= '0;
      flag_q    <= '0;
      itag_q    <= '0;
      i_done_q  <= 1'b0;
      o_done_q  <= 1'b0;
      tmo_cnt_q <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (acc_op) begin
        rs1_q  <= bus.req_rs1;
        rs2_q  <= bus.req_rs2;
        flag_q <= bus.req_flag;
        itag_q <= bus.req_itag;
      end
      i_done_q <= (state_d == S_ISSUE) && i_done_nx;
      o_done_q <= (state_d == S_ISSUE) && o_done_nx;
      if (state_q == S_ISSUE) begin
        if (tmo_cnt_q != CNT_W'(TMO_CYC)) tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
        if (tmo_cnt_q == CNT_W'(TMO_CYC - 1)) tmo_err_q <= 1'b1;
      end else begin
        tmo_cnt_q <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        f_wdat[i] <= '0;
        f_itag[i] <= '0;
        f_ill[i]  <= 1'b0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      f_cnt  <= 2'd0;
    end else begin
      if (push) begin
        f_wdat[wr_ptr] <= push_wdat;
        f_itag[wr_ptr] <= push_itag;
        f_ill[wr_ptr]  <= push_ill;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   f_cnt <= f_cnt + 2'd1;
        2'b01:   f_cnt <= f_cnt - 2'd1;
        default: f_cnt <= f_cnt;
      endcase
    end
  end

  assign bus.req_ready    = req_rdy;
  assign bus.sgnj_i_valid = i_vld;
  assign bus.sgnj_o_ready = o_rdy;
  assign bus.sgnj_rs1     = rs1_q;
  assign bus.sgnj_rs2     = rs2_q;
  assign bus.sgnj_flag    = flag_q;
  assign bus.wbck_valid   = (f_cnt != 2'd0);
  assign bus.wbck_wdat    = f_wdat[rd_ptr];
  assign bus.wbck_itag    = f_itag[rd_ptr];
  assign bus.wbck_ill     = f_ill[rd_ptr];
  assign bus.tmo_err      = tmo_err_q;

endmodule
